// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet TX frame reader.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MIN_FRAME_DEF = 60;

endpackage

// File: rtl/eth_tx_hwbuf.sv
// Two-entry halfword FIFO between the buffer read port and the byte-lane select.
module eth_tx_hwbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] wdata,
  output logic [15:0] head,
  output logic [1:0]  count
);

  logic [15:0] slot [2];
  logic        wr_ptr;
  logic        rd_ptr;

  assign head = slot[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= wdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eth_tx_frame_reader.sv
// Drains one TX frame from the halfword buffer and streams it as bytes, zero-padding
// short frames up to MIN_FRAME.
//   state  | meaning
//   IDLE   | waiting for tx_start; len==0 goes straight to DONE
//   STREAM | fetching halfwords and emitting frame bytes 0..len-1
//   PAD    | emitting 0x00 until MIN_FRAME bytes have gone out
//   DONE   | one-cycle tx_done pulse, then IDLE
module eth_tx_frame_reader
  import eth_tx_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 11,
  parameter int MIN_FRAME = MIN_FRAME_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_int,
  input  logic              rst_int,
  input  logic              tx_start,
  input  logic [LEN_W-1:0]  tx_len,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        tx_tdata,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  output logic              tx_tlast
);

  state_t           state;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] byte_idx;
  logic [LEN_W-1:0] hw_issued;
  logic [LEN_W-1:0] hw_total;
  logic [LEN_W:0]   len_p1;
  logic             in_flight;
  logic [15:0]      head;
  logic [1:0]       occ;
  logic             hs;
  logic             pop;

  assign len_p1    = {1'b0, tx_len} + (LEN_W+1)'(1);
  assign hs        = tx_tvalid & tx_tready;
  assign tx_tvalid = ((state == STREAM) && (occ != 2'd0)) || (state == PAD);
  assign tx_tdata  = (state == STREAM) ? (byte_idx[0] ? head[15:8] : head[7:0]) : 8'h00;
  assign tx_tlast  = tx_tvalid && (byte_idx == last_idx);
  assign tx_busy   = (state == STREAM) || (state == PAD);
  assign tx_done   = (state == DONE);

  // Count in-flight reads as occupied so the FIFO can never overflow.
  assign mem_en   = (state == STREAM) && (hw_issued != hw_total) &&
                    (({1'b0, occ} + {2'b00, in_flight}) < 3'd2);
  assign mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(hw_issued);

  // Odd final byte frees its halfword even though it is a low lane.
  assign pop = hs && (state == STREAM) && (byte_idx[0] || (byte_idx == len_m1));

  eth_tx_hwbuf u_hwbuf (
    .clk   (clk_int),
    .rst   (rst_int),
    .push  (in_flight),
    .pop   (pop),
    .wdata (mem_rdata),
    .head  (head),
    .count (occ)
  );

  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      state     <= IDLE;
      len_m1    <= '0;
      last_idx  <= '0;
      byte_idx  <= '0;
      hw_issued <= '0;
      hw_total  <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= mem_en;
      if (mem_en) hw_issued <= hw_issued + LEN_W'(1);
      case (state)
        IDLE: begin
          if (tx_start) begin
            if (tx_len == '0) begin
              state <= DONE;
            end else begin
              state     <= STREAM;
              len_m1    <= tx_len - LEN_W'(1);
              last_idx  <= (tx_len < LEN_W'(MIN_FRAME)) ? LEN_W'(MIN_FRAME - 1)
                                                        : tx_len - LEN_W'(1);
              hw_total  <= len_p1[LEN_W:1];
              byte_idx  <= '0;
              hw_issued <= '0;
            end
          end
        end
        STREAM: begin
          if (hs) begin
            byte_idx <= byte_idx + LEN_W'(1);
            if (byte_idx == len_m1) state <= (last_idx == len_m1) ? DONE : PAD;
          end
        end
        PAD: begin
          if (hs) begin
            byte_idx <= byte_idx + LEN_W'(1);
            if (byte_idx == last_idx) state <= DONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          byte_idx  <= '0;
          hw_issued <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_reader.sv
// Self-checking bench: byte-stream model from buffer contents, per-cycle compare, directed frames.
module tb_eth_tx_frame_reader;

  localparam int ADDR_W = 11;
  localparam int LEN_W  = 11;
  localparam int MINF   = 60;

  logic              clk_int = 1'b0;
  logic              rst_int = 1'b0;
  logic              tx_start = 1'b0;
  logic [LEN_W-1:0]  tx_len = '0;
  logic              tx_busy, tx_done, mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata = '0;
  logic [7:0]        tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready = 1'b1;
  logic              tx_tlast;

  eth_tx_frame_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MIN_FRAME(MINF), .BASE_ADDR(0)) dut (
    .clk_int   (clk_int),
    .rst_int   (rst_int),
    .tx_start  (tx_start),
    .tx_len    (tx_len),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .tx_tlast  (tx_tlast)
  );

  always #5 clk_int = ~clk_int;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Buffer contents and model state
  logic [15:0] mem_arr [2048];
  int          rd_cnt  [2048];
  logic [7:0]  got     [2048];
  int cyc = 0;
  int cur_len = 0, exp_total = 0, rx_idx = 0;
  int tlast_idx = -1, tlast_cnt = 0, tv_cnt = 0, men_cnt = 0, stall_cnt = 0;
  int last_hs_cyc = 0, done_cyc = 0, s_cyc = 0;
  bit done_flag = 0, stall_prev = 0, rnd_ready = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clk_int) cyc++;

  always @(posedge clk_int) begin
    if (mem_en) begin
      mem_rdata <= mem_arr[mem_addr];
      if (!rst_int) begin
        rd_cnt[mem_addr]++;
        men_cnt++;
      end
    end
  end

  always begin
    @(posedge clk_int);
    #1;
    tx_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [7:0] exp_byte(input int i);
    logic [15:0] hw;
    hw = mem_arr[(i >> 1) % 2048];
    if (i >= cur_len) return 8'h00;
    return i[0] ? hw[15:8] : hw[7:0];
  endfunction

  always @(negedge clk_int) begin
    if (rst_int) begin
      stall_prev = 0;
    end else begin
      if (tx_tvalid) begin
        tv_cnt++;
        if (stall_prev) begin
          chk("stall_tdata", tx_tdata, prev_data);
          chk("stall_tlast", tx_tlast, prev_last);
        end
        if (rx_idx < exp_total) begin
          chk("tdata", tx_tdata, exp_byte(rx_idx));
          chk("tlast", tx_tlast, longint'(rx_idx == exp_total - 1));
        end else begin
          chk("extra_byte", rx_idx, exp_total);
        end
        if (tx_tready) begin
          if (rx_idx < 2048) got[rx_idx] = tx_tdata;
          if (tx_tlast) begin
            tlast_idx = rx_idx;
            tlast_cnt++;
          end
          rx_idx++;
          last_hs_cyc = cyc;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          stall_cnt++;
          prev_data = tx_tdata;
          prev_last = tx_tlast;
        end
      end else begin
        if (stall_prev) chk("tvalid_drop", 0, 1);
        stall_prev = 0;
      end
      if (tx_done) begin
        done_flag = 1;
        done_cyc = cyc;
        chk("busy_at_done", tx_busy, 0);
      end
    end
  end

  task automatic new_frame(input int len);
    cur_len = len;
    exp_total = (len == 0) ? 0 : ((len < MINF) ? MINF : len);
    rx_idx = 0; tlast_idx = -1; tlast_cnt = 0; tv_cnt = 0; men_cnt = 0;
    done_flag = 0; stall_prev = 0;
    for (int a = 0; a < 2048; a++) rd_cnt[a] = 0;
  endtask

  task automatic start_frame(input int len);
    @(posedge clk_int); #1;
    tx_start = 1'b1;
    tx_len = LEN_W'(len);
    s_cyc = cyc;
    @(posedge clk_int); #1;
    tx_start = 1'b0;
    if (len == 0) begin
      chk("zero_len_done", tx_done, 1);
    end else begin
      chk("lat_c1_mem_en", mem_en, 1);
      chk("lat_c1_addr", mem_addr, 0);
      chk("lat_c1_busy", tx_busy, 1);
      @(posedge clk_int); #1;
      chk("lat_c2_tvalid", tx_tvalid, 0);
      @(posedge clk_int); #1;
      chk("lat_c3_tvalid", tx_tvalid, 1);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_int);
      if (done_flag) break;
    end
    if (!done_flag) chk("done_timeout", 0, 1);
    repeat (2) @(posedge clk_int);
  endtask

  task automatic check_frame(input int len);
    int nhw, bad;
    nhw = (len + 1) / 2;
    bad = 0;
    chk("byte_count", rx_idx, exp_total);
    chk("tlast_count", tlast_cnt, (exp_total > 0) ? 1 : 0);
    if (exp_total > 0) begin
      chk("tlast_idx", tlast_idx, exp_total - 1);
      chk("done_latency", done_cyc, last_hs_cyc + 1);
    end else begin
      chk("done_latency", done_cyc, s_cyc + 1);
      chk("zero_len_tvalid", tv_cnt, 0);
    end
    for (int a = 0; a < 2048; a++)
      if (rd_cnt[a] != ((a < nhw) ? 1 : 0)) bad++;
    chk("mem_reads", bad, 0);
    chk("read_total", men_cnt, nhw);
  endtask

  task automatic run_frame(input int len);
    new_frame(len);
    start_frame(len);
    wait_done();
    check_frame(len);
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) mem_arr[k] = {8'(2 * k + 1), 8'(2 * k)};
    #1 rst_int = 1'b1;
    #2;
    chk("rst_tvalid", tx_tvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_tlast", tx_tlast, 0);
    chk("rst_tdata", tx_tdata, 0);
    chk("rst_addr", mem_addr, 0);
    repeat (2) @(posedge clk_int);
    @(negedge clk_int) rst_int = 1'b0;

    // Test 1: full 64-byte frame
    run_frame(64);
    chk("t1_first_byte", got[0], 8'h00);
    chk("t1_last_byte", got[63], 8'h3F);

    // Test 2: odd length at the minimum boundary, no padding
    run_frame(61);
    chk("t2_last_byte", got[60], 8'h3C);
    chk("t2_tlast_idx", tlast_idx, 60);

    // Test 3: short frame padded to 60
    run_frame(10);
    chk("t3_byte9", got[9], 8'h09);
    chk("t3_pad_first", got[10], 8'h00);
    chk("t3_pad_last", got[59], 8'h00);
    chk("t3_tlast_idx", tlast_idx, 59);

    // Test 4: random backpressure
    rnd_ready = 1;
    stall_cnt = 0;
    run_frame(64);
    rnd_ready = 1'b0;
    chk("t4_last_byte", got[63], 8'h3F);
    chk("t4_stalls_seen", longint'(stall_cnt > 0), 1);

    // Test 5: zero length, then a start pulse mid-frame
    run_frame(0);
    new_frame(64);
    start_frame(64);
    repeat (10) @(posedge clk_int);
    #1 tx_start = 1'b1; tx_len = LEN_W'(5);
    @(posedge clk_int); #1 tx_start = 1'b0;
    wait_done();
    check_frame(64);
    chk("t5_last_byte", got[63], 8'h3F);

    // Test 6: reset mid-frame, then a clean frame
    new_frame(64);
    start_frame(64);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_int); #2;
      if (rx_idx >= 21) break;
    end
    chk("t6_reached_byte20", longint'(rx_idx >= 21), 1);
    rst_int = 1'b1;
    #1;
    chk("t6_async_tvalid", tx_tvalid, 0);
    chk("t6_async_mem_en", mem_en, 0);
    chk("t6_async_busy", tx_busy, 0);
    chk("t6_async_done", tx_done, 0);
    repeat (2) @(posedge clk_int);
    @(negedge clk_int) rst_int = 1'b0;
    chk("t6_no_tlast", tlast_cnt, 0);
    chk("t6_no_done", done_flag, 0);
    run_frame(64);
    chk("t6_first_byte", got[0], 8'h00);
    chk("t6_last_byte", got[63], 8'h3F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
